// File: rtl/jsoc_cpu_oci_pkg.sv
// Shared constants and DCT code encodings for the OCI trace path.
package jsoc_cpu_oci_pkg;

  localparam int ENTRY_W     = 2;
  localparam int MAX_ENTRIES = 15;
  localparam int CNT_W       = 4;
  localparam int BUF_W       = ENTRY_W * MAX_ENTRIES;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MAX_ENTRIES);

  typedef enum logic [ENTRY_W-1:0] {
    DCT_RSV = 2'b00,
    DCT_NT  = 2'b01,
    DCT_TK  = 2'b10,
    DCT_IND = 2'b11
  } dct_code_t;

  // Newest code always lands in the low bits; the oldest falls off the top.
  function automatic logic [BUF_W-1:0] dct_shift_in(input logic [BUF_W-1:0] acc,
                                                     input logic [ENTRY_W-1:0] code);
    return {acc[BUF_W-ENTRY_W-1:0], code};
  endfunction

endpackage

// File: rtl/jsoc_cpu_oci_dct_outreg.sv
// One-word valid/ready holding register for packed DCT words.
module jsoc_cpu_oci_dct_outreg
  import jsoc_cpu_oci_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [BUF_W-1:0] load_buf,
  input  logic [CNT_W-1:0] load_cnt,
  input  logic             pkt_ready,
  output logic             pkt_valid,
  output logic [BUF_W-1:0] dct_buffer,
  output logic [CNT_W-1:0] dct_count
);

  logic             valid_reg;
  logic [BUF_W-1:0] buf_reg;
  logic [CNT_W-1:0] cnt_reg;

  // The parent only asserts load when the slot is empty or being drained.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_reg <= 1'b0;
      buf_reg   <= '0;
      cnt_reg   <= '0;
    end else if (load) begin
      valid_reg <= 1'b1;
      buf_reg   <= load_buf;
      cnt_reg   <= load_cnt;
    end else if (pkt_ready) begin
      valid_reg <= 1'b0;
      buf_reg   <= '0;
      cnt_reg   <= '0;
    end
  end

  assign pkt_valid  = valid_reg;
  assign dct_buffer = buf_reg;
  assign dct_count  = cnt_reg;

endmodule

// File: rtl/jsoc_cpu_oci_dct_packer.sv
// Packs 2-bit DCT trace codes into 15-entry words with a drop flag.
// Optional JSOC_DCT_DROP_CNT_EN adds a saturating drop_count output.
module jsoc_cpu_oci_dct_packer
  import jsoc_cpu_oci_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               dct_valid,
  input  logic [ENTRY_W-1:0] dct_code,
  input  logic               flush,
  input  logic               clr_overflow,
  output logic [BUF_W-1:0]   dct_buffer,
  output logic [CNT_W-1:0]   dct_count,
  output logic               pkt_valid,
  input  logic               pkt_ready,
`ifdef JSOC_DCT_DROP_CNT_EN
  output logic [7:0]         drop_count,
`endif
  output logic               overflow
);

  logic [BUF_W-1:0] acc_reg, acc_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             pend_reg, pend_next;
  logic             overflow_reg;

  logic             out_free, flush_req, drop, load;
  logic [BUF_W-1:0] load_buf, grown_buf;
  logic [CNT_W-1:0] load_cnt, grown_cnt;

  always_comb begin
    out_free  = !pkt_valid || pkt_ready;
    flush_req = flush || pend_reg;
    grown_buf = dct_valid ? dct_shift_in(acc_reg, dct_code) : acc_reg;
    grown_cnt = dct_valid ? cnt_reg + CNT_W'(1) : cnt_reg;
    acc_next  = acc_reg;
    cnt_next  = cnt_reg;
    pend_next = pend_reg;
    load      = 1'b0;
    load_buf  = acc_reg;
    load_cnt  = cnt_reg;
    drop      = 1'b0;
    if (cnt_reg == CNT_FULL) begin
      if (out_free) begin
        // Full word leaves; a same-cycle code starts the next word.
        load      = 1'b1;
        acc_next  = dct_valid ? BUF_W'(dct_code) : '0;
        cnt_next  = dct_valid ? CNT_W'(1) : '0;
        pend_next = flush_req && dct_valid;
      end else begin
        drop      = dct_valid;
        pend_next = flush_req;
      end
    end else if (out_free && (grown_cnt == CNT_FULL || (flush_req && grown_cnt != '0))) begin
      load      = 1'b1;
      load_buf  = grown_buf;
      load_cnt  = grown_cnt;
      acc_next  = '0;
      cnt_next  = '0;
      pend_next = 1'b0;
    end else begin
      acc_next  = grown_buf;
      cnt_next  = grown_cnt;
      pend_next = flush_req && grown_cnt != '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_reg      <= '0;
      cnt_reg      <= '0;
      pend_reg     <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      acc_reg  <= acc_next;
      cnt_reg  <= cnt_next;
      pend_reg <= pend_next;
      if (drop)
        overflow_reg <= 1'b1;
      else if (clr_overflow)
        overflow_reg <= 1'b0;
    end
  end

  assign overflow = overflow_reg;

`ifdef JSOC_DCT_DROP_CNT_EN
  logic [7:0] drop_cnt_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      drop_cnt_reg <= '0;
    else if (clr_overflow)
      drop_cnt_reg <= drop ? 8'd1 : 8'd0;
    else if (drop && drop_cnt_reg != 8'hFF)
      drop_cnt_reg <= drop_cnt_reg + 8'd1;
  end

  assign drop_count = drop_cnt_reg;
`endif

  jsoc_cpu_oci_dct_outreg u_outreg (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (load),
    .load_buf   (load_buf),
    .load_cnt   (load_cnt),
    .pkt_ready  (pkt_ready),
    .pkt_valid  (pkt_valid),
    .dct_buffer (dct_buffer),
    .dct_count  (dct_count)
  );

endmodule

// File: tb/tb_jsoc_cpu_oci_dct_packer.sv
// Directed bench for the DCT packer; build with JSOC_DCT_DROP_CNT_EN to also check drop_count.
module tb_jsoc_cpu_oci_dct_packer;
  import jsoc_cpu_oci_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic dct_valid = 1'b0;
  logic [1:0] dct_code = 2'b00;
  logic flush = 1'b0;
  logic clr_overflow = 1'b0;
  logic pkt_ready = 1'b0;
  logic [29:0] dct_buffer;
  logic [3:0] dct_count;
  logic pkt_valid;
  logic overflow;
`ifdef JSOC_DCT_DROP_CNT_EN
  logic [7:0] drop_count;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  jsoc_cpu_oci_dct_packer dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .dct_valid    (dct_valid),
    .dct_code     (dct_code),
    .flush        (flush),
    .clr_overflow (clr_overflow),
    .dct_buffer   (dct_buffer),
    .dct_count    (dct_count),
    .pkt_valid    (pkt_valid),
    .pkt_ready    (pkt_ready),
`ifdef JSOC_DCT_DROP_CNT_EN
    .drop_count   (drop_count),
`endif
    .overflow     (overflow)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    step();
    step();
    checks++;
    if ({pkt_valid, overflow, dct_count, dct_buffer} !== 36'd0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%0b ovf=%0b cnt=%0d buf=%h want all 0",
               pkt_valid, overflow, dct_count, dct_buffer);
    end
    reset_n = 1'b1;
    step();
    $display("reset: valid=%0b cnt=%0d buf=%h", pkt_valid, dct_count, dct_buffer);
  endtask

  task automatic test_full_word();
    pkt_ready = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      dct_valid = 1'b1;
      dct_code  = DCT_TK;
      step();
      if (i == 14) begin
        checks++;
        if (pkt_valid !== 1'b0) begin
          errors++;
          $display("FAIL full_early_valid: got %0b want 0", pkt_valid);
        end
      end
    end
    dct_valid = 1'b0;
    checks++;
    if (pkt_valid !== 1'b1 || dct_count !== 4'd15 || dct_buffer !== 30'h2AAAAAAA) begin
      errors++;
      $display("FAIL full_word: got valid=%0b cnt=%0d buf=%h want 1/15/2aaaaaaa",
               pkt_valid, dct_count, dct_buffer);
    end
    $display("full_word: valid=%0b cnt=%0d buf=%h", pkt_valid, dct_count, dct_buffer);
    step();
    checks++;
    if (pkt_valid !== 1'b0) begin
      errors++;
      $display("FAIL full_word_one_cycle: got valid=%0b want 0", pkt_valid);
    end
  endtask

  task automatic test_flush();
    logic [1:0] codes [3];
    codes[0] = DCT_NT; codes[1] = DCT_TK; codes[2] = DCT_IND;
    pkt_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      dct_valid = 1'b1;
      dct_code  = codes[i];
      step();
    end
    dct_valid = 1'b0;
    flush     = 1'b1;
    step();
    flush = 1'b0;
    checks++;
    if (pkt_valid !== 1'b1 || dct_count !== 4'd3 || dct_buffer !== 30'h0000001B) begin
      errors++;
      $display("FAIL flush_word: got valid=%0b cnt=%0d buf=%h want 1/3/0000001b",
               pkt_valid, dct_count, dct_buffer);
    end
    $display("flush: valid=%0b cnt=%0d buf=%h", pkt_valid, dct_count, dct_buffer);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    step();
    checks++;
    if (pkt_valid !== 1'b0 || dct_count !== 4'd0) begin
      errors++;
      $display("FAIL flush_empty: got valid=%0b cnt=%0d want 0/0", pkt_valid, dct_count);
    end
    $display("flush_empty: valid=%0b", pkt_valid);
  endtask

  task automatic test_overflow();
    pkt_ready = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      dct_valid = 1'b1;
      dct_code  = DCT_NT;
      step();
      if (i == 15) begin
        checks++;
        if (pkt_valid !== 1'b1 || dct_count !== 4'd15 || dct_buffer !== 30'h15555555) begin
          errors++;
          $display("FAIL ovf_first_word: got valid=%0b cnt=%0d buf=%h want 1/15/15555555",
                   pkt_valid, dct_count, dct_buffer);
        end
      end
    end
    checks++;
    if (overflow !== 1'b0 || pkt_valid !== 1'b1) begin
      errors++;
      $display("FAIL ovf_before_drop: got ovf=%0b valid=%0b want 0/1", overflow, pkt_valid);
    end
    step();  // 31st code is dropped
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_set: got %0b want 1", overflow);
    end
`ifdef JSOC_DCT_DROP_CNT_EN
    checks++;
    if (drop_count !== 8'd1) begin
      errors++;
      $display("FAIL drop_count_1: got %0d want 1", drop_count);
    end
`endif
    clr_overflow = 1'b1;  // drop and clear together: the drop wins
    step();
    clr_overflow = 1'b0;
    dct_valid    = 1'b0;
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_set_wins: got %0b want 1", overflow);
    end
`ifdef JSOC_DCT_DROP_CNT_EN
    checks++;
    if (drop_count !== 8'd1) begin
      errors++;
      $display("FAIL drop_count_clr_drop: got %0d want 1", drop_count);
    end
`endif
    pkt_ready = 1'b1;
    step();
    checks++;
    if (pkt_valid !== 1'b1 || dct_count !== 4'd15 || dct_buffer !== 30'h15555555) begin
      errors++;
      $display("FAIL ovf_second_word: got valid=%0b cnt=%0d buf=%h want 1/15/15555555",
               pkt_valid, dct_count, dct_buffer);
    end
    $display("overflow: second word valid=%0b cnt=%0d buf=%h", pkt_valid, dct_count, dct_buffer);
    step();
    checks++;
    if (pkt_valid !== 1'b0) begin
      errors++;
      $display("FAIL ovf_drained: got valid=%0b want 0", pkt_valid);
    end
    clr_overflow = 1'b1;
    step();
    clr_overflow = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear: got %0b want 0", overflow);
    end
`ifdef JSOC_DCT_DROP_CNT_EN
    checks++;
    if (drop_count !== 8'd0) begin
      errors++;
      $display("FAIL drop_count_clear: got %0d want 0", drop_count);
    end
`endif
  endtask

  task automatic test_back_to_back();
    pkt_ready = 1'b0;
    for (int i = 0; i < 30; i++) begin
      dct_valid = 1'b1;
      dct_code  = DCT_TK;
      step();
    end
    pkt_ready = 1'b1;
    dct_code  = DCT_IND;
    step();
    dct_valid = 1'b0;
    pkt_ready = 1'b0;
    checks++;
    if (pkt_valid !== 1'b1 || dct_count !== 4'd15 || dct_buffer !== 30'h2AAAAAAA || overflow !== 1'b0) begin
      errors++;
      $display("FAIL b2b_full_move: got valid=%0b cnt=%0d buf=%h ovf=%0b want 1/15/2aaaaaaa/0",
               pkt_valid, dct_count, dct_buffer, overflow);
    end
    flush = 1'b1;  // output busy, so the flush must wait
    step();
    flush = 1'b0;
    checks++;
    if (dct_count !== 4'd15) begin
      errors++;
      $display("FAIL b2b_hold: got cnt=%0d want 15", dct_count);
    end
    pkt_ready = 1'b1;
    step();
    checks++;
    if (pkt_valid !== 1'b1 || dct_count !== 4'd1 || dct_buffer !== 30'h00000003) begin
      errors++;
      $display("FAIL b2b_pending_flush: got valid=%0b cnt=%0d buf=%h want 1/1/00000003",
               pkt_valid, dct_count, dct_buffer);
    end
    $display("back_to_back: valid=%0b cnt=%0d buf=%h", pkt_valid, dct_count, dct_buffer);
    step();
  endtask

  task automatic test_flush_with_code();
    pkt_ready = 1'b1;
    dct_valid = 1'b1;
    dct_code  = DCT_RSV;
    step();
    dct_code = DCT_TK;
    step();
    dct_code = DCT_IND;
    flush    = 1'b1;
    step();
    dct_valid = 1'b0;
    flush     = 1'b0;
    checks++;
    if (pkt_valid !== 1'b1 || dct_count !== 4'd3 || dct_buffer !== 30'h0000000B) begin
      errors++;
      $display("FAIL flush_same_cycle: got valid=%0b cnt=%0d buf=%h want 1/3/0000000b",
               pkt_valid, dct_count, dct_buffer);
    end
    $display("flush_with_code: valid=%0b cnt=%0d buf=%h", pkt_valid, dct_count, dct_buffer);
    step();
  endtask

  task automatic test_reset_mid_word();
    pkt_ready = 1'b0;
    for (int i = 0; i < 22; i++) begin
      dct_valid = 1'b1;
      dct_code  = DCT_NT;
      step();
    end
    dct_valid = 1'b0;
    checks++;
    if (pkt_valid !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_setup: got valid=%0b want 1", pkt_valid);
    end
    reset_n = 1'b0;
    #2;
    checks++;
    if ({pkt_valid, overflow, dct_count, dct_buffer} !== 36'd0) begin
      errors++;
      $display("FAIL mid_reset_async: got valid=%0b cnt=%0d buf=%h want all 0",
               pkt_valid, dct_count, dct_buffer);
    end
    step();
    reset_n   = 1'b1;
    pkt_ready = 1'b1;
    step();
    for (int i = 0; i < 15; i++) begin
      dct_valid = 1'b1;
      dct_code  = DCT_IND;
      step();
    end
    dct_valid = 1'b0;
    checks++;
    if (pkt_valid !== 1'b1 || dct_count !== 4'd15 || dct_buffer !== 30'h3FFFFFFF) begin
      errors++;
      $display("FAIL mid_reset_clean_word: got valid=%0b cnt=%0d buf=%h want 1/15/3fffffff",
               pkt_valid, dct_count, dct_buffer);
    end
    $display("reset_mid_word: valid=%0b cnt=%0d buf=%h", pkt_valid, dct_count, dct_buffer);
    step();
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_flush();
    test_overflow();
    test_back_to_back();
    test_flush_with_code();
    test_reset_mid_word();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/jsoc_cpu_oci_dct_packer.md
# jsoc_cpu_oci_dct_packer

Packs the CPU's 2-bit direct-control-transfer (DCT) trace codes into 30-bit words holding up to 15 entries, each tagged with an entry count. Sits directly upstream of the OCI trace test bench/FIFO stage and drives its `dct_buffer`/`dct_count` inputs. A one-word output register with a valid/ready handshake decouples packing from the consumer. Codes that cannot be absorbed are dropped and flagged.

## Interface
- `ENTRY_W`, 2, bits per DCT code
- `MAX_ENTRIES`, 15, entries per word; buffer width = `ENTRY_W*MAX_ENTRIES` = 30
- `CNT_W`, 4, width of the entry count
- `clk` in 1, single clock domain
- `reset_n` in 1, asynchronous active-low reset
- `dct_valid` in 1, a DCT code is presented this cycle
- `dct_code` in 2, code (01 not-taken, 10 taken, 11 indirect, 00 reserved)
- `flush` in 1, emit the partial word
- `clr_overflow` in 1, clears the sticky `overflow`
- `dct_buffer` out 30, packed entries, newest in [1:0], unused upper bits 0
- `dct_count` out 4, valid entries in `dct_buffer` (1..15 when `pkt_valid`)
- `pkt_valid` out 1, output word valid
- `pkt_ready` in 1, consumer accepts the word
- `overflow` out 1, sticky: at least one code dropped

## Operation
- Accumulator `acc[29:0]` and `acc_cnt[3:0]`; output register `out_buf`/`out_cnt`/`pkt_valid`.
- `out_free` = !`pkt_valid` || `pkt_ready`.
- Accept: `dct_valid` && (`acc_cnt` < 15 || `out_free`). On accept, `acc` <= {`acc[27:0]`, `dct_code`} and `acc_cnt` is incremented.
- Word complete when an accept brings `acc_cnt` to 15. If `out_free`, the full word, including the new code, loads `out_buf` on the same edge and `acc` clears to 0/0. Otherwise `acc` holds 15 entries.
- Accumulator full (15) and `out_free`: `acc` transfers to the output. Any code presented that cycle is accepted into the emptied accumulator, so `acc_cnt` becomes 1.
- Accumulator full, !`out_free`, and `dct_valid`: the code is dropped and `overflow` sets.
- `flush` with `acc_cnt` > 0 (after counting a same-cycle accepted code) and `out_free`: the partial word moves to the output with its count. If !`out_free`, the flush stays pending (internal flag) until `out_free`. `flush` with an empty accumulator is ignored.
- `clr_overflow` clears `overflow`. If a drop occurs in the same cycle, the set wins.
- Codes are not interpreted. Code 00 is packed like any other code.

## Timing
- Reset (async assert, sync release): `dct_buffer`=0, `dct_count`=0, `pkt_valid`=0, `overflow`=0, `acc`=0, `acc_cnt`=0, flush pending=0.
- Latency: the 15th code accepted at edge N gives `pkt_valid`=1 after edge N. A flush at edge N gives `pkt_valid` after N.
- Handshake: `dct_buffer`/`dct_count` stay stable while `pkt_valid` && !`pkt_ready`. A transfer occurs on an edge with both high. Back-to-back words are supported with no bubble.
- Throughput: one code per cycle sustained while `pkt_ready`=1.
- Reset mid-word discards the accumulator and output word without emitting anything.

## Configuration
- `JSOC_DCT_DROP_CNT_EN` defined: adds output `drop_count[7:0]`, a saturating count of dropped codes (saturates at 255). It is reset to 0 and cleared by `clr_overflow`; a same-cycle drop gives 1.
- Not defined: the port and counter are absent. Only the sticky `overflow` remains.

## Structure
- Shared package `jsoc_cpu_oci_pkg`: `ENTRY_W`, `MAX_ENTRIES`, `CNT_W`, DCT code constants (`DCT_NT`, `DCT_TK`, `DCT_IND`, `DCT_RSV`).
- Sub-module `jsoc_cpu_oci_dct_outreg`: the one-word valid/ready output holding register. All packing and drop logic stays in the parent.

## Test plan
- 15 codes 10 back-to-back, `pkt_ready`=1 → one word `dct_buffer`=0x2AAAAAAA, `dct_count`=15, `pkt_valid` for 1 cycle after the 15th edge.
- Codes 01, 10, 11 then `flush` → `dct_count`=3, `dct_buffer`=0x0000001B. A `flush` on an empty accumulator yields no `pkt_valid`.
- `pkt_ready`=0 and 31 codes 01 → first word held. Accumulator full after 30 codes. The 31st code is dropped, `overflow`=1, `drop_count`=1 (macro on). Raise `pkt_ready` → two words of 15 entries each, no bubble.
- Accumulator full, output occupied, `pkt_ready`=1 with `dct_valid` in the same cycle → old word consumed, full accumulator moves to output, new code gives `acc_cnt`=1, no drop.
- `flush` with `dct_valid` code 11 in the same cycle on a 2-entry accumulator → word with count 3 and 11 in [1:0].
- `reset_n` low mid-word (7 entries, `pkt_valid`=1) → all outputs 0 immediately. After release, 15 codes produce a clean count-15 word.
